// File: rtl/ysyx_25030093_pkg.sv
// Shared definitions for the ysyx_25030093 core front end.
//   XLEN    : width of pc and instruction words
//   entry_t : one fetched {pc, inst} pair as carried from IFU to IDU
package ysyx_25030093_pkg;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } entry_t;

endpackage

// File: rtl/ifu_idu_queue_mem.sv
// Storage array for the IFU->IDU queue: DEPTH x WIDTH registers, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
module ifu_idu_queue_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifu_idu_queue.sv
// Instruction queue between fetch (IFU) and decode (IDU). Buffers {pc, inst}
// pairs with valid/ready on both sides and supports a one-cycle flush on redirect.
//   clk_i/rst_ni                   : clock, async active-low reset
//   in_valid_i/in_ready_o          : IFU handshake; in_pc_i/in_inst_i carry the entry
//   out_valid_o/out_ready_i        : IDU handshake; out_pc_o/out_inst_o show the head
//   flush_i                        : drop all entries at the next edge
//   count_o                        : current occupancy
module ifu_idu_queue
   import ysyx_25030093_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [XLEN-1:0]        in_inst_i,
   input  logic [XLEN-1:0]        in_pc_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [XLEN-1:0]        out_inst_o,
   output logic [XLEN-1:0]        out_pc_o,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop, has_data;
   entry_t          wr_entry, rd_entry;

   assign has_data    = (count_q != '0);
   assign in_ready_o  = (count_q != CntW'(DEPTH)) & ~flush_i;
   assign out_valid_o = has_data & ~flush_i;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign count_o     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally at PtrW bits; count tells full from empty.
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_d = count_q + CntW'(1);
         else if (pop && !push) count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry = '{pc: in_pc_i, inst: in_inst_i};

   ifu_idu_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // Gate on occupancy (not flush) so data reads 0 out of reset yet stays stable
   // while the head waits on out_ready.
   assign out_pc_o   = has_data ? rd_entry.pc   : '0;
   assign out_inst_o = has_data ? rd_entry.inst : '0;

   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CntW'(DEPTH));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      pop |-> (count_q != '0));
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (count_q != CntW'(DEPTH)));

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Self-checking bench for ifu_idu_queue: a vector table for fill/drain plus
// hand-written sequences, all checked against a queue-based scoreboard.
module tb_ifu_idu_queue;
   import ysyx_25030093_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic            clk, rst_n;
   logic            in_valid, in_ready, out_valid, out_ready, flush;
   logic [XLEN-1:0] in_inst, in_pc, out_inst, out_pc;
   logic [2:0]      count;

   int     n_cmp = 0;
   int     n_err = 0;
   entry_t sb[$];

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        ordy;
      logic        fl;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[10];

   ifu_idu_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_inst_i   (in_inst),
      .in_pc_i     (in_pc),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_inst_o  (out_inst),
      .out_pc_o    (out_pc),
      .flush_i     (flush),
      .count_o     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; drives inputs, checks pre-edge outputs against the
   // scoreboard, updates the scoreboard and returns at the next posedge+1.
   task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
      bit     exp_push, exp_pop;
      entry_t e;
      in_valid  = iv;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
      #2;
      exp_push = iv && (sb.size() != DEPTH) && !fl;
      exp_pop  = ordy && (sb.size() != 0) && !fl;
      chk("in_ready", in_ready, (sb.size() != DEPTH) && !fl);
      chk("out_valid", out_valid, (sb.size() != 0) && !fl);
      chk("count", count, sb.size());
      if (sb.size() != 0 && !fl) begin
         chk("out_pc", out_pc, sb[0].pc);
         chk("out_inst", out_inst, sb[0].inst);
      end
      if (fl) begin
         sb.delete();
      end else begin
         if (exp_pop) e = sb.pop_front();
         if (exp_push) sb.push_back('{pc: pc, inst: inst});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_pop(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++)
         tbl[i] = '{1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0000_0413 + 32'(i << 20),
                    1'b0, 1'b0, i + 1};
      tbl[4] = '{1'b1, 32'h8000_0010, 32'h0040_0213, 1'b0, 1'b0, 4};
      tbl[5] = '{1'b1, 32'h8000_0010, 32'h0040_0213, 1'b0, 1'b0, 4};
      for (int i = 6; i < 10; i++)
         tbl[i] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 9 - i};

      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      out_ready = 1'b0; flush = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_inst", out_inst, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Fill to full, hold off a fifth push, drain in order.
      foreach (tbl[i]) begin
         cycle(tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
      end

      // Simultaneous push/pop at count 2 across pointer wrap.
      cycle(1'b1, 32'h8000_0200, 32'h0000_0001, 1'b0, 1'b0);
      cycle(1'b1, 32'h8000_0204, 32'h0000_0002, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h8000_0208 + 32'(4 * i), 32'h0000_0010 + 32'(i), 1'b1, 1'b0);
         chk("pushpop_count", count, 3'd2);
      end
      idle_pop(2);

      // Empty-to-first latency and back-pressure hold.
      cycle(1'b1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
      chk("latency_out_valid", out_valid, 1'b1);
      cycle(1'b1, 32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         chk("hold_out_pc", out_pc, 32'h8000_0004);
         chk("hold_out_inst", out_inst, 32'h0010_0093);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("release_out_pc", out_pc, 32'h8000_0008);
      idle_pop(1);

      // Flush with concurrent traffic at count 3.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h8000_0300 + 32'(4 * i), 32'h0000_0100 + 32'(i), 1'b0, 1'b0);
      cycle(1'b1, 32'h8000_00F0, 32'hDEAD_BEEF, 1'b1, 1'b1);
      chk("flush_count", count, 3'd0);
      chk("flush_out_valid", out_valid, 1'b0);
      cycle(1'b1, 32'h8000_0100, 32'h0000_0013, 1'b0, 1'b0);
      chk("post_flush_out_valid", out_valid, 1'b1);
      chk("post_flush_out_pc", out_pc, 32'h8000_0100);
      chk("post_flush_count", count, 3'd1);
      idle_pop(1);

      // Asynchronous reset mid-traffic at count 3.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h8000_0400 + 32'(4 * i), 32'h0000_0200 + 32'(i), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 3'd0);
      chk("async_rst_out_valid", out_valid, 1'b0);
      sb.delete();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'h8000_0500, 32'h0000_0033, 1'b0, 1'b0);
      idle_pop(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_idu_queue.md
Name: ifu_idu_queue

Overview:
- Instruction queue between the fetch stage (IFU) and the decode stage (IDU) of the ysyx_25030093 core.
- Buffers fetched {pc, inst} pairs with valid/ready handshakes on both sides.
- Decouples fetch latency from decode stalls.
- Supports a single-cycle flush when the writeback stage redirects the PC.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- XLEN, 32, width of the pc and inst fields

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  IFU presents a fetched instruction
- in_ready  out  1  queue can accept this cycle
- in_inst  in  XLEN  fetched instruction word
- in_pc  in  XLEN  pc of the fetched instruction
- out_valid  out  1  queue head is valid for IDU
- out_ready  in  1  IDU consumes head this cycle
- out_inst  out  XLEN  head instruction
- out_pc  out  XLEN  head pc
- flush  in  1  discard all entries (redirect from WBU)
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr and count cleared to 0.
  - out_valid=0, in_ready=1 once rst deasserts.
  - out_inst and out_pc read 0 (storage array need not be reset).
  - Reset asserted mid-operation drops all entries immediately, with no clock edge needed.
- Handshake rules:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Transfers happen only on the rising clk edge.
- Status flags:
  - in_ready = (count != DEPTH) & !flush. Combinational, no dependency on out_ready; a full queue does not accept in the same cycle as a pop.
  - out_valid = (count != 0) & !flush.
- Output data:
  - out_inst and out_pc are driven combinationally from storage[rd_ptr].
  - They are held stable while out_valid & !out_ready (no change without pop or flush).
- Latency:
  - An entry pushed at edge N is visible on out_* after edge N; minimum in-to-out latency is 1 cycle.
  - There is no combinational bypass.
- Push: storage[wr_ptr] <= {in_pc, in_inst}; wr_ptr increments modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
  - neither: hold
- Flush:
  - Highest priority: at the edge, wr_ptr, rd_ptr and count are set to 0.
  - Any in_valid/out_ready that cycle performs no transfer, because in_ready and out_valid are both forced to 0.
  - Flush is a single cycle; an entry may be pushed on the cycle after flush deasserts.
- Full (count==DEPTH): in_ready=0. IFU must hold in_valid, in_inst and in_pc stable until accepted.
- Empty (count==0): out_valid=0; out_inst/out_pc are don't-care.
- Pointer wrap-around requires no special handling; the design never relies on pointer equality alone, count disambiguates full from empty.
- Assertions (sim only):
  - count never exceeds DEPTH.
  - Pop never occurs when count==0.
  - Push never occurs when count==DEPTH.

Decomposition:
- Shared package ysyx_25030093_pkg holds XLEN and the entry struct {pc, inst} typedef; DEPTH stays a local parameter.
- One natural sub-module: ifu_idu_queue_mem, a DEPTH x 2*XLEN register array with one write port and one asynchronous read port, no reset. The control (pointers, count, flags) stays in the top.

Test Plan:
- Reset then idle:
  - rst low for 2 cycles, then high.
  - Expect out_valid=0, in_ready=1, count=0.
  - Asserting rst low mid-traffic with count=3 forces count=0 and out_valid=0 without a clock edge.
- Fill to full:
  - Push pc=0x80000000/inst=0x00000413, then pc+4..pc+12 with out_ready=0.
  - count reaches 4, in_ready=0, and a 5th in_valid is held off.
  - Draining yields the same 4 pcs in order.
- Simultaneous push/pop at count=2:
  - count stays 2, both pointers advance.
  - Run 10 cycles across pointer wrap; outputs preserve order with no loss or duplication.
- Back-pressure hold:
  - With out_valid=1, hold out_ready=0 for 5 cycles.
  - out_pc/out_inst stay constant (e.g. 0x80000004/0x00100093).
  - When released, the next entry appears one cycle later.
- Flush with concurrent traffic:
  - At count=3, assert flush with in_valid=1 and out_ready=1.
  - Next cycle count=0, out_valid=0; the flush-cycle input is not captured.
  - Pushing pc=0x80000100 the following cycle appears at out_pc one cycle later.
- Empty-to-first latency:
  - Push into an empty queue at edge N; out_valid rises after edge N, never in the push cycle.
